// File: rtl/ltl_monitor_hub_if.sv
// rtl/ltl_monitor_hub_if.sv - violation event port between the monitor hub and its consumer
interface ltl_monitor_hub_if #(
   parameter int PID_W = 2,
   parameter int SYM_W = 8,
   parameter int TS_W  = 32
) ();
   logic             evt_valid;
   logic             evt_ready;
   logic [PID_W-1:0] evt_prop_id;
   logic [SYM_W-1:0] evt_symbol;
   logic [TS_W-1:0]  evt_timestamp;
   logic             evt_overflow;

   modport master (
      output evt_valid,
      output evt_prop_id,
      output evt_symbol,
      output evt_timestamp,
      output evt_overflow,
      input  evt_ready
   );

   modport slave (
      input  evt_valid,
      input  evt_prop_id,
      input  evt_symbol,
      input  evt_timestamp,
      input  evt_overflow,
      output evt_ready
   );
endinterface

// File: rtl/ltl_monitor_hub.sv
// rtl/ltl_monitor_hub.sv - reduces LTL automaton report states into hits, sticky flags,
// saturating counters and a single-entry violation event register
module ltl_monitor_hub #(
   parameter int  NUM_PROPS  = 4,
   parameter int  NUM_REPORT = 4,
   parameter int  SYM_W      = 8,
   parameter int  CNT_W      = 16,
   parameter int  TS_W       = 32,
   localparam int PID_W      = (NUM_PROPS > 1) ? $clog2(NUM_PROPS) : 1
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           run,
   input  logic                           clear,
   input  logic [SYM_W-1:0]               symbols,
   input  logic [NUM_PROPS*NUM_REPORT-1:0] report_in,
   input  logic [NUM_PROPS-1:0]           prop_enable,
   output logic [NUM_PROPS-1:0]           ltl_hit,
   output logic [NUM_PROPS-1:0]           ltl_flag,
   output logic                           any_flag,
   input  logic [PID_W-1:0]               cnt_sel,
   output logic [CNT_W-1:0]               viol_count,
   ltl_monitor_hub_if.master              evt
);

   logic [NUM_PROPS-1:0] raw;
   logic                 any_raw;
   logic                 multi_raw;
   logic [PID_W-1:0]     low_pid;
   logic                 handshake;
   logic                 evt_free;

   logic [NUM_PROPS-1:0] hit_q, hit_d;
   logic [NUM_PROPS-1:0] flag_q, flag_d;
   logic [CNT_W-1:0]     cnt_q [NUM_PROPS];
   logic [CNT_W-1:0]     cnt_d [NUM_PROPS];
   logic [TS_W-1:0]      ts_q, ts_d;

   logic                 evt_valid_q, evt_valid_d;
   logic [PID_W-1:0]     evt_pid_q, evt_pid_d;
   logic [SYM_W-1:0]     evt_sym_q, evt_sym_d;
   logic [TS_W-1:0]      evt_ts_q, evt_ts_d;
   logic                 evt_ovf_q, evt_ovf_d;

   always_comb begin
      raw = '0;
      for (int p = 0; p < NUM_PROPS; p++) begin
         raw[p] = run & prop_enable[p] & (|report_in[p*NUM_REPORT +: NUM_REPORT]);
      end
   end

   // Descending scan so the lowest set index wins.
   always_comb begin
      low_pid = '0;
      for (int p = NUM_PROPS - 1; p >= 0; p--) begin
         if (raw[p]) begin
            low_pid = PID_W'(p);
         end
      end
   end

   assign any_raw   = |raw;
   assign multi_raw = |(raw & (raw - NUM_PROPS'(1)));
   assign handshake = evt_valid_q & evt.evt_ready;
   assign evt_free  = ~evt_valid_q | handshake;

   always_comb begin
      hit_d  = raw;
      flag_d = flag_q | raw;
      cnt_d  = cnt_q;
      ts_d   = ts_q;
      for (int p = 0; p < NUM_PROPS; p++) begin
         if (raw[p] && (cnt_q[p] != {CNT_W{1'b1}})) begin
            cnt_d[p] = cnt_q[p] + CNT_W'(1);
         end
      end
      if (run) begin
         ts_d = ts_q + TS_W'(1);
      end
      if (clear) begin
         hit_d  = '0;
         flag_d = '0;
         ts_d   = '0;
         for (int p = 0; p < NUM_PROPS; p++) begin
            cnt_d[p] = '0;
         end
      end
   end

   // A hit that cannot be captured only marks the pending event as overflowed.
   always_comb begin
      evt_valid_d = evt_valid_q;
      evt_pid_d   = evt_pid_q;
      evt_sym_d   = evt_sym_q;
      evt_ts_d    = evt_ts_q;
      evt_ovf_d   = evt_ovf_q;
      if (clear) begin
         evt_valid_d = 1'b0;
         evt_pid_d   = '0;
         evt_sym_d   = '0;
         evt_ts_d    = '0;
         evt_ovf_d   = 1'b0;
      end else if (evt_free && any_raw) begin
         evt_valid_d = 1'b1;
         evt_pid_d   = low_pid;
         evt_sym_d   = symbols;
         evt_ts_d    = ts_q;
         evt_ovf_d   = multi_raw;
      end else if (handshake) begin
         evt_valid_d = 1'b0;
         evt_ovf_d   = 1'b0;
      end else if (any_raw) begin
         evt_ovf_d   = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hit_q       <= '0;
         flag_q      <= '0;
         ts_q        <= '0;
         evt_valid_q <= 1'b0;
         evt_pid_q   <= '0;
         evt_sym_q   <= '0;
         evt_ts_q    <= '0;
         evt_ovf_q   <= 1'b0;
         for (int p = 0; p < NUM_PROPS; p++) begin
            cnt_q[p] <= '0;
         end
      end else begin
         hit_q       <= hit_d;
         flag_q      <= flag_d;
         ts_q        <= ts_d;
         evt_valid_q <= evt_valid_d;
         evt_pid_q   <= evt_pid_d;
         evt_sym_q   <= evt_sym_d;
         evt_ts_q    <= evt_ts_d;
         evt_ovf_q   <= evt_ovf_d;
         for (int p = 0; p < NUM_PROPS; p++) begin
            cnt_q[p] <= cnt_d[p];
         end
      end
   end

   // Out-of-range selects read as zero when NUM_PROPS is not a power of two.
   always_comb begin
      viol_count = '0;
      for (int p = 0; p < NUM_PROPS; p++) begin
         if (cnt_sel == PID_W'(p)) begin
            viol_count = cnt_q[p];
         end
      end
   end

   assign ltl_hit           = hit_q;
   assign ltl_flag          = flag_q;
   assign any_flag          = |flag_q;
   assign evt.evt_valid     = evt_valid_q;
   assign evt.evt_prop_id   = evt_pid_q;
   assign evt.evt_symbol    = evt_sym_q;
   assign evt.evt_timestamp = evt_ts_q;
   assign evt.evt_overflow  = evt_ovf_q;

endmodule

// File: doc/ltl_monitor_hub.md
Name: ltl_monitor_hub

Overview:
Parametrised collection stage for the runtime-verification monitors. It takes the report-state vectors of NUM_PROPS LTL property automata and reduces them per property into registered violation pulses and sticky flags. It keeps a saturating violation count per property and captures violation events (property id, symbol, timestamp) into a ready/valid event port. It sits between an Automata_Stage instance and the core's trace/debug logic.

Parameters:
NUM_PROPS, 4, number of monitored LTL properties (1..32)
NUM_REPORT, 4, reporting states per property
SYM_W, 8, width of the symbol bus
CNT_W, 16, width of each per-property violation counter
TS_W, 32, width of the run-cycle timestamp
PID_W, $clog2(NUM_PROPS) (minimum 1), property-id width (derived, not overridden)

Ports:
clk  in  1  clock; all logic is rising-edge
reset  in  1  asynchronous active-low reset (0 = reset asserted)
run  in  1  monitor enable; symbol/report inputs are valid only when 1
clear  in  1  synchronous clear of flags, counters, timestamp, event and overflow
symbols  in  SYM_W  symbol presented to the automata this cycle
report_in  in  NUM_PROPS*NUM_REPORT  report-state outputs; property p occupies bits [p*NUM_REPORT +: NUM_REPORT]
prop_enable  in  NUM_PROPS  per-property mask
ltl_hit  out  NUM_PROPS  registered one-cycle violation pulse per property
ltl_flag  out  NUM_PROPS  sticky violation flag per property
any_flag  out  1  OR of ltl_flag
cnt_sel  in  PID_W  selects the counter shown on viol_count
viol_count  out  CNT_W  counter of property cnt_sel (combinational read)
evt_valid  out  1  event register holds an unconsumed event
evt_ready  in  1  consumer accepts the event
evt_prop_id  out  PID_W  property id of the held event
evt_symbol  out  SYM_W  symbol registered with the hit
evt_timestamp  out  TS_W  timestamp value on the hit cycle
evt_overflow  out  1  one or more hits were dropped while this event was pending or captured

Behaviour:
- Reset (reset=0, asynchronous): all outputs and registers are 0, including every counter, the timestamp and the event register.
- Precedence: reset > clear > normal operation. clear=1 zeroes everything on the next edge and ignores hits in that cycle.
- raw[p] = run & prop_enable[p] & (OR of property p's report slice).
- ltl_hit[p] registers raw[p]. Latency is exactly 1 cycle.
- ltl_flag[p] sets on the edge where raw[p]=1 and holds until clear or reset.
- Counter p increments by 1 on each raw[p]=1 cycle and saturates at 2^CNT_W-1 (no wrap).
- Timestamp ts increments by 1 on each cycle with run=1 and wraps modulo 2^TS_W. The value captured is ts before that cycle's increment.
- run=0: no hits, ts frozen, all state held. An event already held stays valid and can still be consumed.
- cnt_sel >= NUM_PROPS: viol_count = 0.
- Event port:
  - Handshake completes on an edge where evt_valid & evt_ready.
  - The register is free when evt_valid=0 or a handshake completes this cycle.
  - Free and any raw=1: capture the lowest-index p with raw[p]=1, plus symbols and ts. evt_valid=1 on the next edge.
  - evt_overflow for the new event = 1 if other raw bits were set in the same cycle, else 0.
  - Not free and any raw=1: the hit is dropped from the event port (flags and counters still update) and evt_overflow sets to 1.
  - While evt_valid=1, all evt_* outputs are stable until the handshake.
  - Handshake with no new hit: evt_valid=0 and evt_overflow=0 on the next edge.
  - evt_valid never depends combinationally on evt_ready.
- prop_enable changes take effect for the same-cycle raw computation. Disabling a property does not clear its flag or counter.

Test Plan:
- Reset/idle: hold reset=0 for 3 cycles, then release with run=0 and report_in=all ones -> every output stays 0 and ts stays 0.
- Single hit: run=1 from ts=0; at ts=5 set report_in bit 6 (p=1) with symbols=8'hA5 -> ltl_hit=4'b0010 for one cycle; ltl_flag[1]=1; event reads {prop 1, A5, ts 5, overflow 0}; viol_count(sel=1)=1.
- Simultaneous/backpressure:
  - Same cycle, p0 and p3 fire with evt_ready=0 -> event prop 0 with overflow=1; counters for p0 and p3 each = 1.
  - A further p2 hit is dropped; the event is unchanged.
  - Assert evt_ready -> evt_valid=0 and evt_overflow=0 on the next edge.
- Back-to-back: evt_ready held at 1 and p2 fires on 3 consecutive cycles -> 3 consecutive events with ts n, n+1, n+2, all overflow=0.
- Saturation: CNT_W=3 and p0 fires 10 times -> viol_count stops at 7. Separately, with TS_W=4, ts wraps 15->0.
- Clear/mask: prop_enable[0]=0 and p0 fires -> no hit, flag, count or event. Mid-event clear=1 -> all flags, counters, evt_valid and ts are 0 on the next edge. reset=0 asserted mid-event -> outputs 0 immediately, asynchronous to clk.
